// File: rtl/trap_sequencer.sv
// trap_sequencer: turns memory-stage faults and external interrupt requests
// into fixed sequences of one-hot step codes for the control unit. It also
// captures the faulting/return PC and flushes the front of the pipeline.
module trap_sequencer #(
    parameter int PC_WIDTH = 32,
    parameter bit INT_EDGE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                int_req,
    input  logic                exc_stack,
    input  logic                exc_mem,
    input  logic [PC_WIDTH-1:0] pc_in,
    output logic [3:0]          exceptions,
    output logic [2:0]          interrupts,
    output logic                flush,
    output logic                busy,
    output logic                int_ack,
    output logic [PC_WIDTH-1:0] epc
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXC1 = 3'd1,
        EXC2 = 3'd2,
        EXC3 = 3'd3,
        INT1 = 3'd4,
        INT2 = 3'd5,
        INT3 = 3'd6
    } state_t;

    typedef enum logic {
        CAUSE_STACK = 1'b0,
        CAUSE_MEM   = 1'b1
    } cause_t;

    state_t              state;
    state_t              state_nx;
    cause_t              cause;
    cause_t              cause_nx;
    logic [PC_WIDTH-1:0] epc_nx;

    // Pending requests waiting for the sequencer to return to IDLE
    logic                exc_pend;
    cause_t              exc_pend_cause;
    logic                int_pend;
    logic                int_req_q;

    logic                exc_evt;
    cause_t              evt_cause;
    logic                int_evt;
    logic                take_exc;
    logic                take_int;

    // Exception step code; the first step encodes which cause is being served
    function automatic logic [3:0] exc_code(input state_t s, input cause_t c);
        logic [3:0] code;
        code = 4'b0000;
        case (s)
            EXC1:    code = (c == CAUSE_STACK) ? 4'b0001 : 4'b0010;
            EXC2:    code = 4'b0100;
            EXC3:    code = 4'b1000;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    // Interrupt step code
    function automatic logic [2:0] int_code(input state_t s);
        logic [2:0] code;
        code = 3'b000;
        case (s)
            INT1:    code = 3'b001;
            INT2:    code = 3'b010;
            INT3:    code = 3'b100;
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Flush is raised only in the first step of either sequence
    function automatic logic flush_of(input state_t s);
        return (s == EXC1) || (s == INT1);
    endfunction

    // Interrupt acknowledge coincides with the last interrupt step
    function automatic logic ack_of(input state_t s);
        return (s == INT3);
    endfunction

    // A simultaneous stack and mem fault is reported as stack; mem is dropped
    assign exc_evt   = exc_stack | exc_mem;
    assign evt_cause = exc_stack ? CAUSE_STACK : CAUSE_MEM;

    // Edge mode compares against the previous sample; level mode uses it raw
    assign int_evt   = INT_EDGE ? (int_req & ~int_req_q) : int_req;

    // Next-state, cause and EPC selection; everything holds while stalled
    always_comb begin
        state_nx = state;
        cause_nx = cause;
        epc_nx   = epc;
        take_exc = 1'b0;
        take_int = 1'b0;
        if (!stall) begin
            case (state)
                IDLE: begin
                    if (exc_pend) begin
                        state_nx = EXC1;
                        cause_nx = exc_pend_cause;
                        epc_nx   = pc_in;
                        take_exc = 1'b1;
                    end else if (int_pend) begin
                        state_nx = INT1;
                        epc_nx   = pc_in;
                        take_int = 1'b1;
                    end
                end
                EXC1:    state_nx = EXC2;
                EXC2:    state_nx = EXC3;
                EXC3:    state_nx = IDLE;
                INT1:    state_nx = INT2;
                INT2:    state_nx = INT3;
                INT3:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, pending capture and registered Moore outputs
    always_ff @(posedge clk) begin
        // Track int_req even in reset so a level held across reset is not
        // mistaken for a fresh rising edge once reset is released.
        int_req_q <= int_req;
        if (!reset) begin
            state          <= IDLE;
            cause          <= CAUSE_STACK;
            epc            <= '0;
            exc_pend       <= 1'b0;
            exc_pend_cause <= CAUSE_STACK;
            int_pend       <= 1'b0;
            exceptions     <= 4'b0000;
            interrupts     <= 3'b000;
            flush          <= 1'b0;
            busy           <= 1'b0;
            int_ack        <= 1'b0;
        end else begin
            state <= state_nx;
            cause <= cause_nx;
            epc   <= epc_nx;

            // A fault arriving as the previous one is taken starts a new
            // pending entry; otherwise the first recorded cause is kept.
            if (exc_evt && (take_exc || !exc_pend)) begin
                exc_pend       <= 1'b1;
                exc_pend_cause <= evt_cause;
            end else if (take_exc) begin
                exc_pend <= 1'b0;
            end

            // Requests merge into an already pending interrupt
            if (int_evt) begin
                int_pend <= 1'b1;
            end else if (take_int) begin
                int_pend <= 1'b0;
            end

            exceptions <= exc_code(state_nx, cause_nx);
            interrupts <= int_code(state_nx);
            flush      <= flush_of(state_nx);
            busy       <= (state_nx != IDLE);
            int_ack    <= ack_of(state_nx);
        end
    end

endmodule
